// File: rtl/led_pkg.sv
// Shared constants and types for the LED panel receiver.
package led_pkg;

  localparam int unsigned COLS_DEF     = 32;
  localparam int unsigned ROW_BITS_DEF = 3;

  typedef logic [2:0] rgb_t;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } rx_state_t;

endpackage : led_pkg

// File: rtl/led_edge_det.sv
// Input register plus rising-edge pulse (pulse is combinational from the
// registered level and its one-cycle-old copy).
module led_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise_c
);

  logic r_sig;
  logic r_sig_prev;

  // Sample the input and keep the previous sample for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sig      <= 1'b0;
      r_sig_prev <= 1'b0;
    end else begin
      r_sig      <= i_sig;
      r_sig_prev <= r_sig;
    end
  end

  assign o_rise_c = r_sig & ~r_sig_prev;

endmodule : led_edge_det

// File: rtl/led_panel_rx.sv
// Receiver for the RGB LED matrix panel bus. Shifts column data on sclk
// rising edges, captures a row on latch rising edges and replays it as
// 2*COLS frame-buffer writes (top half, then bottom half). Protocol
// violations are reported on sticky error flags.
// Optional build macro: LED_RX_SYNC_EN adds a two-flop synchronizer in
// front of the input register stage for an asynchronous source.
module led_panel_rx
  import led_pkg::*;
#(
  parameter int unsigned COLS     = COLS_DEF,
  parameter int unsigned ROW_BITS = ROW_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                LEDs1,
  input  logic [2:0]                LEDs2,
  input  logic [ROW_BITS-1:0]       rowSelect,
  input  logic                      blank,
  input  logic                      latch,
  input  logic                      sclk,
  output logic                      pix_we,
  output logic                      pix_half,
  output logic [ROW_BITS-1:0]       pix_row,
  output logic [$clog2(COLS)-1:0]   pix_col,
  output rgb_t                      pix_rgb,
  output logic                      row_done,
  output logic                      err_len,
  output logic                      err_overrun,
  output logic                      err_unblanked
);

  localparam int unsigned CW  = $clog2(COLS);
  localparam int unsigned BCW = CW + 1;
  localparam int unsigned WCW = CW + 2;
  localparam int unsigned INW = 3 + 3 + ROW_BITS + 3;

  // ------------------------------------------------------------------
  // Input conditioning
  // ------------------------------------------------------------------
  logic [INW-1:0]      w_raw;
  logic [INW-1:0]      w_in;
  logic                w_sclk_in;
  logic                w_latch_in;
  logic                w_blank_in;
  logic [ROW_BITS-1:0] w_row_in;
  rgb_t                w_leds1_in;
  rgb_t                w_leds2_in;

  assign w_raw = {sclk, latch, blank, rowSelect, LEDs2, LEDs1};

`ifdef LED_RX_SYNC_EN
  logic [INW-1:0] r_sync1;
  logic [INW-1:0] r_sync2;

  // Two-flop synchronizer on every bus signal
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_in = r_sync2;
`else
  assign w_in = w_raw;
`endif

  assign {w_sclk_in, w_latch_in, w_blank_in, w_row_in, w_leds2_in, w_leds1_in} = w_in;

  rgb_t                r_leds1;
  rgb_t                r_leds2;
  logic [ROW_BITS-1:0] r_row;
  logic                r_blank;
  logic                w_sclk_rise;
  logic                w_latch_rise;

  // Register stage r for the data-carrying inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds1 <= '0;
      r_leds2 <= '0;
      r_row   <= '0;
      r_blank <= 1'b0;
    end else begin
      r_leds1 <= w_leds1_in;
      r_leds2 <= w_leds2_in;
      r_row   <= w_row_in;
      r_blank <= w_blank_in;
    end
  end

  led_edge_det u_sclk_edge (
    .clk      (clk),
    .reset    (reset),
    .i_sig    (w_sclk_in),
    .o_rise_c (w_sclk_rise)
  );

  led_edge_det u_latch_edge (
    .clk      (clk),
    .reset    (reset),
    .i_sig    (w_latch_in),
    .o_rise_c (w_latch_rise)
  );

  // ------------------------------------------------------------------
  // Shift path (independent of the dump engine)
  // ------------------------------------------------------------------
  rgb_t [COLS-1:0] r_sh1;
  rgb_t [COLS-1:0] r_sh2;
  rgb_t [COLS-1:0] w_sh1_post;
  rgb_t [COLS-1:0] w_sh2_post;
  logic [BCW-1:0]  r_bit_cnt;
  logic [BCW-1:0]  w_cnt_post;

  // Shift-register and bit-count values after this cycle's sclk edge; a
  // coincident latch sees these, so the simultaneous bit is captured
  always_comb begin
    w_sh1_post = r_sh1;
    w_sh2_post = r_sh2;
    w_cnt_post = r_bit_cnt;
    if (w_sclk_rise) begin
      w_sh1_post = {r_sh1[COLS-2:0], r_leds1};
      w_sh2_post = {r_sh2[COLS-2:0], r_leds2};
      if (r_bit_cnt != BCW'(COLS)) begin
        w_cnt_post = r_bit_cnt + BCW'(1);
      end
    end
  end

  // Shift registers and saturating bit counter; any latch edge restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh1     <= '0;
      r_sh2     <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_sh1     <= w_sh1_post;
      r_sh2     <= w_sh2_post;
      r_bit_cnt <= w_latch_rise ? BCW'(0) : w_cnt_post;
    end
  end

  // ------------------------------------------------------------------
  // Capture and dump engine
  // ------------------------------------------------------------------
  rx_state_t           r_state;
  rx_state_t           w_state_nxt;
  logic [WCW-1:0]      r_wr_cnt;
  logic [WCW-1:0]      w_wr_cnt_nxt;
  rgb_t [COLS-1:0]     r_hold1;
  rgb_t [COLS-1:0]     r_hold2;
  rgb_t [COLS-1:0]     w_hold1_nxt;
  rgb_t [COLS-1:0]     w_hold2_nxt;
  logic                w_we_nxt;
  logic                w_half_nxt;
  logic [ROW_BITS-1:0] w_row_nxt;
  logic [CW-1:0]       w_col_nxt;
  rgb_t                w_rgb_nxt;
  logic                w_row_done_nxt;
  logic                w_err_len_nxt;
  logic                w_err_ovr_nxt;
  logic                w_err_unb_nxt;
  logic [CW-1:0]       w_cur_col;
  logic                w_cur_half;

  // Write index layout: MSB-1 selects the half, low bits select the column
  assign w_cur_col  = r_wr_cnt[CW-1:0];
  assign w_cur_half = r_wr_cnt[CW];

  // Next-state and next-output logic; write 0 is issued together with the
  // capture, the remaining 2*COLS-1 writes come from the hold registers
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_hold1_nxt    = r_hold1;
    w_hold2_nxt    = r_hold2;
    w_we_nxt       = 1'b0;
    w_half_nxt     = pix_half;
    w_row_nxt      = pix_row;
    w_col_nxt      = pix_col;
    w_rgb_nxt      = pix_rgb;
    w_row_done_nxt = 1'b0;
    w_err_len_nxt  = err_len;
    w_err_ovr_nxt  = err_overrun;
    w_err_unb_nxt  = err_unblanked;

    case (r_state)
      IDLE: begin
        if (w_latch_rise) begin
          w_hold1_nxt  = w_sh1_post;
          w_hold2_nxt  = w_sh2_post;
          w_row_nxt    = r_row;
          w_we_nxt     = 1'b1;
          w_half_nxt   = 1'b0;
          w_col_nxt    = '0;
          w_rgb_nxt    = w_sh1_post[0];
          w_wr_cnt_nxt = WCW'(1);
          w_state_nxt  = DUMP;
          if (w_cnt_post != BCW'(COLS)) begin
            w_err_len_nxt = 1'b1;
          end
          if (!r_blank) begin
            w_err_unb_nxt = 1'b1;
          end
        end
      end

      DUMP: begin
        if (w_latch_rise) begin
          w_err_ovr_nxt = 1'b1;
        end
        if (r_wr_cnt == WCW'(2 * COLS)) begin
          w_row_done_nxt = 1'b1;
          w_wr_cnt_nxt   = '0;
          w_state_nxt    = IDLE;
        end else begin
          w_we_nxt     = 1'b1;
          w_half_nxt   = w_cur_half;
          w_col_nxt    = w_cur_col;
          w_rgb_nxt    = w_cur_half ? r_hold2[w_cur_col] : r_hold1[w_cur_col];
          w_wr_cnt_nxt = r_wr_cnt + WCW'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, hold registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_wr_cnt      <= '0;
      r_hold1       <= '0;
      r_hold2       <= '0;
      pix_we        <= 1'b0;
      pix_half      <= 1'b0;
      pix_row       <= '0;
      pix_col       <= '0;
      pix_rgb       <= '0;
      row_done      <= 1'b0;
      err_len       <= 1'b0;
      err_overrun   <= 1'b0;
      err_unblanked <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_cnt      <= w_wr_cnt_nxt;
      r_hold1       <= w_hold1_nxt;
      r_hold2       <= w_hold2_nxt;
      pix_we        <= w_we_nxt;
      pix_half      <= w_half_nxt;
      pix_row       <= w_row_nxt;
      pix_col       <= w_col_nxt;
      pix_rgb       <= w_rgb_nxt;
      row_done      <= w_row_done_nxt;
      err_len       <= w_err_len_nxt;
      err_overrun   <= w_err_ovr_nxt;
      err_unblanked <= w_err_unb_nxt;
    end
  end

endmodule : led_panel_rx

// File: tb/tb_led_panel_rx.sv
// Self-checking bench for led_panel_rx: directed scenarios with random
// pixel data, checked against a history-based model of the panel bus.
module tb_led_panel_rx;
  import led_pkg::*;

  localparam int COLS     = 32;
  localparam int ROW_BITS = 3;
  localparam int CW       = $clog2(COLS);

  logic                clk = 1'b0;
  logic                reset;
  logic [2:0]          LEDs1;
  logic [2:0]          LEDs2;
  logic [ROW_BITS-1:0] rowSelect;
  logic                blank;
  logic                latch;
  logic                sclk;
  logic                pix_we;
  logic                pix_half;
  logic [ROW_BITS-1:0] pix_row;
  logic [CW-1:0]       pix_col;
  rgb_t                pix_rgb;
  logic                row_done;
  logic                err_len;
  logic                err_overrun;
  logic                err_unblanked;

  led_panel_rx #(.COLS(COLS), .ROW_BITS(ROW_BITS)) dut (
    .clk           (clk),
    .reset         (reset),
    .LEDs1         (LEDs1),
    .LEDs2         (LEDs2),
    .rowSelect     (rowSelect),
    .blank         (blank),
    .latch         (latch),
    .sclk          (sclk),
    .pix_we        (pix_we),
    .pix_half      (pix_half),
    .pix_row       (pix_row),
    .pix_col       (pix_col),
    .pix_rgb       (pix_rgb),
    .row_done      (row_done),
    .err_len       (err_len),
    .err_overrun   (err_overrun),
    .err_unblanked (err_unblanked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        half;
    logic [7:0]  row;
    logic [7:0]  col;
    logic [2:0]  rgb;
    logic [31:0] cyc;
  } wr_t;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  wr_t         saved_q[$];
  int unsigned got_rd[$];
  int unsigned exp_rd[$];
  int unsigned cyc = 0;

  // Model state: every bit shifted since reset, bits since last latch,
  // time of the last accepted latch and the expected sticky errors
  int hist1[$];
  int hist2[$];
  int bit_cnt_m;
  int last_acc;
  bit d_sclk;
  bit d_latch;
  bit exp_len;
  bit exp_ovr;
  bit exp_unb;
  int g_row;
  bit g_blk;

  int n_tests = 0;
  int n_fail  = 0;

  // Cycle counter: number of rising clk edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // Collect every frame-buffer write and row_done pulse
  always @(negedge clk) begin
    wr_t w;
    if (pix_we === 1'b1) begin
      w.half = pix_half;
      w.row  = 8'(pix_row);
      w.col  = 8'(pix_col);
      w.rgb  = pix_rgb;
      w.cyc  = cyc;
      got_q.push_back(w);
    end
    if (row_done === 1'b1) got_rd.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    hist1.delete();
    hist2.delete();
    bit_cnt_m = 0;
    last_acc  = -100000;
    exp_len   = 1'b0;
    exp_ovr   = 1'b0;
    exp_unb   = 1'b0;
    d_sclk    = 1'b0;
    d_latch   = 1'b0;
    exp_q.delete();
    exp_rd.delete();
  endtask

  // Drive one clock of bus values and advance the model by the same clock
  task automatic step(input bit rst, input bit s, input bit l, input int v1, input int v2);
    bit s_rise;
    bit l_rise;
    reset     = rst;
    sclk      = s;
    latch     = l;
    LEDs1     = 3'(v1);
    LEDs2     = 3'(v2);
    rowSelect = ROW_BITS'(g_row);
    blank     = g_blk;
    if (rst) begin
      model_clear();
    end else begin
      s_rise  = s && !d_sclk;
      l_rise  = l && !d_latch;
      d_sclk  = s;
      d_latch = l;
      if (s_rise) begin
        hist1.push_back(v1 & 7);
        hist2.push_back(v2 & 7);
        if (bit_cnt_m < COLS) bit_cnt_m++;
      end
      if (l_rise) begin
        if (int'(cyc) - last_acc >= 2 * COLS + 1) begin
          if (bit_cnt_m != COLS) exp_len = 1'b1;
          if (!g_blk) exp_unb = 1'b1;
          for (int h = 0; h < 2; h++) begin
            for (int c = 0; c < COLS; c++) begin
              wr_t w;
              int  idx;
              idx   = hist1.size() - 1 - c;
              w.half = 1'(h);
              w.row  = 8'(g_row);
              w.col  = 8'(c);
              w.rgb  = (idx >= 0) ? 3'((h == 0) ? hist1[idx] : hist2[idx]) : 3'd0;
              w.cyc  = 32'(int'(cyc) + 2 + h * COLS + c);
              exp_q.push_back(w);
            end
          end
          exp_rd.push_back(32'(int'(cyc) + 2 + 2 * COLS));
          last_acc = int'(cyc);
        end else begin
          exp_ovr = 1'b1;
        end
        bit_cnt_m = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input int v1, input int v2);
    step(1'b0, 1'b1, 1'b0, v1, v2);
    step(1'b0, 1'b0, 1'b0, v1, v2);
  endtask

  task automatic shift_rand(input int n);
    for (int i = 0; i < n; i++) shift_bit(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
  endtask

  task automatic do_latch();
    step(1'b0, 1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic settle();
    idle(2 * COLS + 6);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Compare collected writes, row_done pulses and error flags to the model
  task automatic check_dump(input string tag);
    chk({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_wr"}, 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_nrd"}, 64'(got_rd.size()), 64'(exp_rd.size()));
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
      chk({tag, "_rdcyc"}, 64'(got_rd[i]), 64'(exp_rd[i]));
    chk({tag, "_err_len"}, 64'(err_len), 64'(exp_len));
    chk({tag, "_err_ovr"}, 64'(err_overrun), 64'(exp_ovr));
    chk({tag, "_err_unb"}, 64'(err_unblanked), 64'(exp_unb));
    got_q.delete();
    exp_q.delete();
    got_rd.delete();
    exp_rd.delete();
  endtask

  initial begin
    bit found;
    int v1;
    int v2;
    int col;

    g_row = 0;
    g_blk = 1'b1;
    reset = 1'b1;
    sclk = 1'b0;
    latch = 1'b0;
    LEDs1 = '0;
    LEDs2 = '0;
    rowSelect = '0;
    blank = 1'b1;
    model_clear();

    // Reset state
    do_reset();
    chk("rst_we", 64'(pix_we), 64'(0));
    chk("rst_half", 64'(pix_half), 64'(0));
    chk("rst_row", 64'(pix_row), 64'(0));
    chk("rst_col", 64'(pix_col), 64'(0));
    chk("rst_rgb", 64'(pix_rgb), 64'(0));
    chk("rst_done", 64'(row_done), 64'(0));
    chk("rst_elen", 64'(err_len), 64'(0));
    chk("rst_eovr", 64'(err_overrun), 64'(0));
    chk("rst_eunb", 64'(err_unblanked), 64'(0));

    // Full row with a recognisable pattern on row 5
    g_row = 5;
    for (int i = 0; i < COLS; i++) begin
      col = COLS - 1 - i;
      shift_bit(col % 8, (~col) & 7);
    end
    do_latch();
    settle();
    if (got_q.size() == 2 * COLS) begin
      for (int c = 0; c < COLS; c++) begin
        chk("pat_top", 64'(got_q[c].rgb), 64'(c % 8));
        chk("pat_bot", 64'(got_q[COLS + c].rgb), 64'((~c) & 7));
      end
      chk("pat_row", 64'(got_q[0].row), 64'(5));
    end
    chk("hold_we", 64'(pix_we), 64'(0));
    chk("hold_col", 64'(pix_col), 64'(COLS - 1));
    chk("hold_half", 64'(pix_half), 64'(1));
    chk("pat_elen", 64'(err_len), 64'(0));
    check_dump("pattern");

    // Short row: err_len set
    g_row = 2;
    shift_rand(COLS - 1);
    do_latch();
    settle();
    chk("short_elen", 64'(err_len), 64'(1));
    check_dump("short");

    // Long row: err_len stays set, last COLS bits captured
    shift_rand(40);
    do_latch();
    settle();
    chk("long_elen", 64'(err_len), 64'(1));
    check_dump("long");
    do_reset();
    chk("clr_elen", 64'(err_len), 64'(0));

    // Second latch 10 cycles after the first: overrun, first row kept
    g_row = 6;
    shift_rand(COLS);
    do_latch();
    shift_rand(4);
    do_latch();
    settle();
    chk("ovr_flag", 64'(err_overrun), 64'(1));
    chk("ovr_nwr", 64'(got_q.size()), 64'(2 * COLS));
    check_dump("overrun");

    // Minimum row period: 2*COLS+1 accepted, 2*COLS is an overrun
    do_reset();
    g_row = 1;
    shift_rand(COLS);
    do_latch();
    idle(2 * COLS - 1);
    do_latch();
    settle();
    chk("minper_ovr", 64'(err_overrun), 64'(0));
    chk("minper_nrd", 64'(got_rd.size()), 64'(2));
    check_dump("minper");
    do_latch();
    idle(2 * COLS - 2);
    do_latch();
    settle();
    chk("tight_ovr", 64'(err_overrun), 64'(1));
    check_dump("tight");

    // sclk and latch edges together on the last bit
    do_reset();
    g_row = 3;
    shift_rand(COLS - 1);
    v1 = int'($urandom_range(0, 7));
    v2 = int'($urandom_range(0, 7));
    step(1'b0, 1'b1, 1'b1, v1, v2);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    settle();
    chk("simul_elen", 64'(err_len), 64'(0));
    if (got_q.size() == 2 * COLS) begin
      chk("simul_top0", 64'(got_q[0].rgb), 64'(v1));
      chk("simul_bot0", 64'(got_q[COLS].rgb), 64'(v2));
    end
    check_dump("simul");

    // Latch while unblanked: flagged, dump still happens
    do_reset();
    g_blk = 1'b0;
    g_row = 7;
    shift_rand(COLS);
    do_latch();
    settle();
    chk("unb_flag", 64'(err_unblanked), 64'(1));
    chk("unb_nwr", 64'(got_q.size()), 64'(2 * COLS));
    check_dump("unblank");
    g_blk = 1'b1;

    // Reset during write 20 of a dump
    do_reset();
    g_row = 4;
    shift_rand(COLS);
    do_latch();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (pix_we === 1'b1 && pix_half === 1'b0 && pix_col === CW'(19)) found = 1'b1;
      else step(1'b0, 1'b0, 1'b0, 0, 0);
    end
    chk("mid_found", 64'(found), 64'(1));
    saved_q = exp_q;
    step(1'b1, 1'b0, 1'b0, 0, 0);
    chk("mid_we", 64'(pix_we), 64'(0));
    chk("mid_col", 64'(pix_col), 64'(0));
    chk("mid_rgb", 64'(pix_rgb), 64'(0));
    chk("mid_row", 64'(pix_row), 64'(0));
    chk("mid_done", 64'(row_done), 64'(0));
    step(1'b0, 1'b0, 1'b0, 0, 0);
    settle();
    chk("mid_nwr", 64'(got_q.size()), 64'(20));
    chk("mid_nrd", 64'(got_rd.size()), 64'(0));
    for (int i = 0; i < got_q.size() && i < 20 && i < saved_q.size(); i++)
      chk("mid_wr", 64'(got_q[i]), 64'(saved_q[i]));
    got_q.delete();
    got_rd.delete();

    // Random rows with random lengths, rows, blanking and spacing
    do_reset();
    for (int it = 0; it < 6; it++) begin
      g_row = int'($urandom_range(0, 7));
      g_blk = ($urandom_range(0, 3) != 0);
      shift_rand(int'($urandom_range(28, 36)));
      do_latch();
      idle(int'($urandom_range(0, 8)));
    end
    settle();
    check_dump("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_led_panel_rx
